axis_elastic_buffer: RTL and testbench
======================================

// Module: axis_elastic_buffer
// PURPOSE
//  Parametrised AXI-Stream elastic buffer: successor to the 2-entry skid stage, generalised to DEPTH entries.
//  Registered m_axis outputs, full 1-beat/cycle throughput, occupancy level, almost-full flag, synchronous flush.
//  Sits between PDCCH pipeline stages (config/payload paths) where more than one beat of back-pressure slack is needed.
// PARAMETERS
//  DATA_WIDTH   64  payload width in bits (PDCCH instances override with $bits of the carried struct)
//  DEPTH         4  total capacity in beats, output register included; power of 2, >=2
//  AFULL_THRESH  3  almost_full asserted when level >= AFULL_THRESH; 1..DEPTH
//  LW           $clog2(DEPTH+1)  level width (localparam)
// PORTS
//  clk           in   1            clock, all logic on posedge
//  reset         in   1            synchronous, active-high
//  flush         in   1            synchronous discard of all stored beats
//  s_axis_valid  in   1            upstream beat valid
//  s_axis_data   in   DATA_WIDTH   upstream payload
//  s_axis_ready  out  1            buffer can accept a beat this cycle
//  m_axis_valid  out  1            registered; downstream beat valid
//  m_axis_data   out  DATA_WIDTH   registered; downstream payload
//  m_axis_ready  in   1            downstream accepts
//  level         out  LW           registered beats held (output reg + storage), 0..DEPTH
//  almost_full   out  1            registered; level >= AFULL_THRESH
// BEHAVIOUR
//  - Reset: m_axis_valid=0, m_axis_data=0, level=0, almost_full=0, s_axis_ready=1, rd/wr pointers=0.
//  - Handshake: push = s_axis_valid & s_axis_ready; pop = m_axis_valid & m_axis_ready. Standard AXI-S rules:
//    m_axis_valid/data stay stable while m_axis_valid & !m_axis_ready; s_axis_ready never depends on s_axis_valid.
//  - s_axis_ready = (level != DEPTH) | m_axis_ready is NOT allowed; s_axis_ready = (level < DEPTH), registered-derived.
//  - Storage: output register + circular array of DEPTH-1 entries, rd/wr pointers wrap modulo DEPTH-1.
//  - Latency: empty buffer, push in cycle N -> m_axis_valid=1 with that data in cycle N+1 (bypass into output reg).
//  - Output reg refill: on pop (or output reg empty), load head of array if non-empty, else load s_axis_data if push,
//    else m_axis_valid<=0. Order strictly FIFO; no beat duplicated or dropped.
//  - level(next) = level + push - pop; simultaneous push & pop at level==DEPTH impossible (ready=0);
//    at level==DEPTH with pop, ready rises the next cycle (one-cycle bubble on input side, accepted).
//  - Sustained push & pop with level in 1..DEPTH-1: level constant, one beat/cycle each side.
//  - almost_full, level updated same edge as the push/pop causing them.
//  - flush: next cycle level=0, m_axis_valid=0, pointers=0, s_axis_ready=1; any push in the flush cycle is
//    discarded; flush has priority over push/pop; reset has priority over flush.
//  - Reset or flush mid-burst: in-flight beats discarded, no partial state retained.
//  - m_axis_data when m_axis_valid=0: held last value (see CONFIGURATION).
// CONFIGURATION
//  AXIS_ELASTIC_LOWPOWER_EN defined: m_axis_data forced to 0 whenever m_axis_valid is 0 (after pop with nothing
//    to load, after flush); array entries zeroed on read. Reduces toggling on wide PDCCH config buses.
//  Not defined: m_axis_data and array retain stale values; no zeroing logic synthesised.
//  Handshake, level, latency identical in both builds.
// TESTING
//  1 Reset, empty: push 0xA1 at cycle 0, m_axis_ready=1 -> m_axis_valid=1, data=0xA1 at cycle 1, level back to 0 at 2.
//  2 m_axis_ready=0, push 0x01..0x04 (DEPTH=4) -> level 1,2,3,4; almost_full at level 3; s_axis_ready=0 at level 4;
//    5th beat held off; release ready -> 0x01..0x04 out in order, then 5th beat.
//  3 Continuous push & pop 1000 random beats, random m_axis_ready 50% -> output sequence equals input, no loss/dup.
//  4 level=3, assert flush with concurrent push 0xFF -> next cycle level=0, m_axis_valid=0, 0xFF never emitted.
//  5 Assert reset mid-burst at level=2 -> all outputs at reset values next cycle; new push after reset emerges alone.
//  6 LOWPOWER build: drain to empty -> m_axis_data==0 while m_axis_valid=0; default build: data holds last beat.

Source files
------------

// File: rtl/axis_elastic_buffer.sv
// AXI-Stream elastic buffer: registered output stage backed by a (DEPTH-1)-entry circular array.
// Optional macro AXIS_ELASTIC_LOWPOWER_EN zeroes idle output data and array entries once read.
module axis_elastic_buffer #(
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = 3,
  localparam int LW          = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  s_axis_valid,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  output logic                  s_axis_ready,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  input  logic                  m_axis_ready,
  output logic [LW-1:0]         level,
  output logic                  almost_full
);

  localparam int AW = DEPTH - 1;
  localparam int PW = (AW > 1) ? $clog2(AW) : 1;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  afull_q, afull_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [AW];
  logic [DATA_WIDTH-1:0] mem_d [AW];

  logic push, pop, load_out, arr_empty, arr_rd, arr_wr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(AW-1)) ? '0 : p + 1'b1;
  endfunction

  // Ready comes only from registered level, never from downstream ready.
  assign s_axis_ready = (level_q < LW'(DEPTH));
  assign push         = s_axis_valid & s_axis_ready;
  assign pop          = out_valid_q & m_axis_ready;
  assign load_out     = pop | ~out_valid_q;
  // Array occupancy is whatever the level holds beyond the output register.
  assign arr_empty    = (level_q == LW'(out_valid_q));
  assign arr_rd       = load_out & ~arr_empty;
  assign arr_wr       = push & ~(load_out & arr_empty);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    mem_d       = mem_q;

    if (load_out) begin
      if (!arr_empty) begin
        out_valid_d = 1'b1;
        out_data_d  = mem_q[rd_ptr_q];
      end else if (push) begin
        out_valid_d = 1'b1;
        out_data_d  = s_axis_data;
      end else begin
        out_valid_d = 1'b0;
`ifdef AXIS_ELASTIC_LOWPOWER_EN
        out_data_d  = '0;
`endif
      end
    end

    if (arr_rd) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
`ifdef AXIS_ELASTIC_LOWPOWER_EN
      mem_d[rd_ptr_q] = '0;
`endif
    end
    // Write after the zeroing so a full-array read/write to one slot keeps the new beat.
    if (arr_wr) begin
      mem_d[wr_ptr_q] = s_axis_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end

    level_d = level_q + LW'(push) - LW'(pop);

    if (flush) begin
      out_valid_d = 1'b0;
      level_d     = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
`ifdef AXIS_ELASTIC_LOWPOWER_EN
      out_data_d  = '0;
`endif
    end

    afull_d = (level_d >= LW'(AFULL_THRESH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      level_q     <= '0;
      afull_q     <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      level_q     <= level_d;
      afull_q     <= afull_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign m_axis_valid = out_valid_q;
  assign m_axis_data  = out_data_q;
  assign level        = level_q;
  assign almost_full  = afull_q;

endmodule

// File: tb/tb_axis_elastic_buffer.sv
// Scoreboard bench for axis_elastic_buffer (DEPTH=4, AFULL_THRESH=3, 8-bit data).
module tb_axis_elastic_buffer;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int LW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          reset, flush;
  logic          s_valid, s_ready;
  logic [W-1:0]  s_data;
  logic          m_valid, m_ready;
  logic [W-1:0]  m_data;
  logic [LW-1:0] level;
  logic          afull;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] sb[$];
  logic         done_rand;

  always #5 clk = ~clk;

  axis_elastic_buffer #(.DATA_WIDTH(W), .DEPTH(D), .AFULL_THRESH(AF)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .s_axis_valid(s_valid), .s_axis_data(s_data), .s_axis_ready(s_ready),
    .m_axis_valid(m_valid), .m_axis_data(m_data), .m_axis_ready(m_ready),
    .level(level), .almost_full(afull)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected beats on every output handshake, and checks hold-while-stalled.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;
  always @(negedge clk) begin
    if (reset || flush) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", {31'd0, m_valid}, 32'd1);
        chk("stall_data_hold", {24'd0, m_data}, {24'd0, prev_data});
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL out_unexpected: got 0x%0h expected no beat at %0t", m_data, $time);
        end else begin
          chk("out_data", {24'd0, m_data}, {24'd0, sb.pop_front()});
        end
      end
      prev_stall <= m_valid & ~m_ready;
      prev_data  <= m_data;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    bit ok = 0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_ready) begin
        sb.push_back(d);
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (level == 0 && !m_valid) begin ok = 1; break; end
      step();
    end
    chk("drain_done", {31'd0, ok}, 32'd1);
    chk("sb_empty", sb.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    done_rand = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data", {24'd0, m_data}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_afull", {31'd0, afull}, 32'd0);
    chk("rst_sready", {31'd0, s_ready}, 32'd1);

    // 1: single beat, one-cycle latency, level returns to 0
    m_ready = 1'b1;
    send(8'hA1);
    chk("t1_valid", {31'd0, m_valid}, 32'd1);
    chk("t1_data", {24'd0, m_data}, 32'hA1);
    chk("t1_level1", {29'd0, level}, 32'd1);
    step();
    chk("t1_level0", {29'd0, level}, 32'd0);
    chk("t1_valid0", {31'd0, m_valid}, 32'd0);

    // 2: fill against back-pressure, then release
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send(W'(i));
      chk("t2_level", {29'd0, level}, i);
      chk("t2_afull", {31'd0, afull}, (i >= AF) ? 32'd1 : 32'd0);
      chk("t2_sready", {31'd0, s_ready}, (i < D) ? 32'd1 : 32'd0);
    end
    fork
      send(8'h05);
      begin
        repeat (3) step();
        chk("t2_held_level", {29'd0, level}, 32'd4);
        chk("t2_held_sready", {31'd0, s_ready}, 32'd0);
        m_ready = 1'b1;
        step();
        chk("t2_pop_level", {29'd0, level}, 32'd3);
        chk("t2_pop_sready", {31'd0, s_ready}, 32'd1);
      end
    join
    drain();

    // 3: random traffic with random downstream ready
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) step();
          send(W'($urandom));
        end
        done_rand = 1'b1;
      end
      begin
        while (!done_rand) begin
          step();
          m_ready = $urandom_range(0, 1) == 1;
        end
      end
    join
    drain();

    // 4: flush at level 3 with a concurrent push
    m_ready = 1'b0;
    send(8'h31); send(8'h32); send(8'h33);
    chk("t4_level3", {29'd0, level}, 32'd3);
    s_valid = 1'b1; s_data = 8'hFF; flush = 1'b1;
    step();
    flush = 1'b0; s_valid = 1'b0;
    sb.delete();
    chk("t4_level", {29'd0, level}, 32'd0);
    chk("t4_valid", {31'd0, m_valid}, 32'd0);
    chk("t4_sready", {31'd0, s_ready}, 32'd1);
    chk("t4_afull", {31'd0, afull}, 32'd0);
`ifdef AXIS_ELASTIC_LOWPOWER_EN
    chk("t4_data_lp", {24'd0, m_data}, 32'd0);
`else
    chk("t4_data_hold", {24'd0, m_data}, 32'h31);
`endif
    m_ready = 1'b1;
    repeat (3) step();
    chk("t4_no_emit", {31'd0, m_valid}, 32'd0);

    // 5: reset mid-burst at level 2
    m_ready = 1'b0;
    send(8'h51); send(8'h52);
    chk("t5_level2", {29'd0, level}, 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    chk("t5_valid", {31'd0, m_valid}, 32'd0);
    chk("t5_data", {24'd0, m_data}, 32'd0);
    chk("t5_level", {29'd0, level}, 32'd0);
    chk("t5_sready", {31'd0, s_ready}, 32'd1);
    m_ready = 1'b1;
    send(8'h5A);
    chk("t5_new_valid", {31'd0, m_valid}, 32'd1);
    chk("t5_new_data", {24'd0, m_data}, 32'h5A);
    step();

    // 6: idle data after draining
    chk("t6_valid", {31'd0, m_valid}, 32'd0);
    chk("t6_level", {29'd0, level}, 32'd0);
`ifdef AXIS_ELASTIC_LOWPOWER_EN
    chk("t6_data_lp", {24'd0, m_data}, 32'd0);
`else
    chk("t6_data_hold", {24'd0, m_data}, 32'h5A);
`endif
    chk("t6_sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
